// File: rtl/fifo_arb_pkg.sv
// Shared types for fifo_push_arb: FSM state encoding and the owner/pointer index width.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of a requester index; never below one bit.
    function automatic int ptr_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/fifo_push_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; first set req bit at or after ptr, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   idx,
    output logic            valid
);

    logic [PW-1:0] cand_s;
    logic          hit_s;

    // Scan offsets 0..NREQ-1 from ptr; only the first hit updates idx.
    always_comb begin
        idx    = '0;
        valid  = 1'b0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = PW'((int'(ptr) + i) % NREQ);
            hit_s  = req[cand_s] & ~valid;
            idx    = hit_s ? cand_s : idx;
            valid  = valid | req[cand_s];
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin push arbiter with per-grant burst limit feeding a shift-register FIFO.
// Optional per-requester starvation check enabled by macro FIFO_ARB_STARVE_CHK_EN.
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int BURST      = 4,
    parameter int STARVE_MAX = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic                  full,
    output logic [NREQ-1:0]       grant,
    output logic                  push,
    output logic [WIDTH-1:0]      data_out,
    output logic                  starve_err
);

    localparam int PW = ptr_w(NREQ);
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    arb_state_e    state_q, state_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pick_idx_s;
    logic          pick_valid_s;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .idx   (pick_idx_s),
        .valid (pick_valid_s)
    );

    // Next-state, burst accounting and FIFO-facing outputs.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant    = '0;
        push     = 1'b0;
        data_out = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d = BUSY;
                    owner_d = pick_idx_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                grant[owner_q] = 1'b1;
                push           = req[owner_q] & ~full;
                data_out       = req_data[int'(owner_q)*WIDTH +: WIDTH];
                // A dropped request or the last push of the burst hands the bus on.
                if (!req[owner_q] || (push && (cnt_q == CW'(BURST - 1)))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ptr_d   = PW'((int'(owner_q) + 1) % NREQ);
                end else if (push) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_ARB_STARVE_CHK_EN
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] wait_q [NREQ];
    logic [SW-1:0] wait_d [NREQ];
    logic          hit_s;
    logic          starve_q;

    // Saturating wait counters; a grant clears the owner's count.
    always_comb begin
        wait_d = wait_q;
        hit_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                wait_d[i] = '0;
            end else if (req[i] && (wait_q[i] != SW'(STARVE_MAX))) begin
                wait_d[i] = wait_q[i] + SW'(1);
            end else begin
                wait_d[i] = wait_q[i];
            end
            hit_s = hit_s | (wait_d[i] == SW'(STARVE_MAX));
        end
    end

    // Wait counters and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                wait_q[i] <= '0;
            end
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_q | hit_s;
        end
    end

    assign starve_err = starve_q;
`else
    assign starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb (NREQ=4, BURST=4, WIDTH=8): vector table plus push scoreboard.
module tb_fifo_push_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  grant;
    logic        push;
    logic [7:0]  data_out;
    logic        starve_err;

    int ntests;
    int nfail;

    typedef struct {
        logic [3:0]  req;
        logic        full;
        logic [31:0] rdata;
        logic [3:0]  exp_grant;
        logic        exp_push;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];

    fifo_push_arb #(
        .WIDTH      (8),
        .NREQ       (4),
        .BURST      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .full       (full),
        .grant      (grant),
        .push       (push),
        .data_out   (data_out),
        .starve_err (starve_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of grant/push/data_out and scoreboard drain on push.
    task automatic check_cycle(input string nm, input logic [3:0] eg, input logic ep, input logic [7:0] ed);
        logic [7:0] sb_exp;
        chk({nm, " grant"}, {28'h0, grant}, {28'h0, eg});
        chk({nm, " push"}, {31'h0, push}, {31'h0, ep});
        chk({nm, " data_out"}, {24'h0, data_out}, {24'h0, ed});
        chk({nm, " push_vs_full"}, {31'h0, push & full}, 32'h0);
        if (push === 1'b1) begin
            if (sb.size() == 0) begin
                chk({nm, " sb_unexpected_push"}, 32'h1, 32'h0);
            end else begin
                sb_exp = sb.pop_front();
                chk({nm, " sb_data"}, {24'h0, data_out}, {24'h0, sb_exp});
            end
        end
    endtask

    function automatic vec_t mk(input logic [3:0] r, input logic f, input logic [31:0] d,
                                input logic [3:0] g, input logic p, input logic [7:0] o);
        vec_t v;
        v.req = r; v.full = f; v.rdata = d;
        v.exp_grant = g; v.exp_push = p; v.exp_data = o;
        return v;
    endfunction

    initial begin
        ntests   = 0;
        nfail    = 0;
        rst      = 1'b1;
        req      = 4'b1111;
        req_data = 32'h13121110;
        full     = 1'b0;

        // Burst, stall, early-drop and ptr-wrap vectors, starting from IDLE with ptr=0.
        vecs.push_back(mk(4'b0001, 1'b0, 32'h000000A0, 4'b0000, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0001, 1'b0, 32'h000000A0, 4'b0001, 1'b1, 8'hA0));
        vecs.push_back(mk(4'b0001, 1'b0, 32'h000000A1, 4'b0001, 1'b1, 8'hA1));
        vecs.push_back(mk(4'b0001, 1'b0, 32'h000000A2, 4'b0001, 1'b1, 8'hA2));
        vecs.push_back(mk(4'b0001, 1'b0, 32'h000000A3, 4'b0001, 1'b1, 8'hA3));
        vecs.push_back(mk(4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0011, 1'b0, 32'h0000B055, 4'b0000, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0011, 1'b0, 32'h0000B055, 4'b0010, 1'b1, 8'hB0));
        vecs.push_back(mk(4'b0011, 1'b0, 32'h0000B155, 4'b0010, 1'b1, 8'hB1));
        vecs.push_back(mk(4'b0011, 1'b1, 32'h0000B255, 4'b0010, 1'b0, 8'hB2));
        vecs.push_back(mk(4'b0011, 1'b1, 32'h0000B255, 4'b0010, 1'b0, 8'hB2));
        vecs.push_back(mk(4'b0011, 1'b1, 32'h0000B255, 4'b0010, 1'b0, 8'hB2));
        vecs.push_back(mk(4'b0011, 1'b0, 32'h0000B255, 4'b0010, 1'b1, 8'hB2));
        vecs.push_back(mk(4'b0011, 1'b0, 32'h0000B355, 4'b0010, 1'b1, 8'hB3));
        vecs.push_back(mk(4'b0101, 1'b0, 32'h00C00000, 4'b0000, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0101, 1'b0, 32'h00C00000, 4'b0100, 1'b1, 8'hC0));
        vecs.push_back(mk(4'b0101, 1'b0, 32'h00C10000, 4'b0100, 1'b1, 8'hC1));
        vecs.push_back(mk(4'b1001, 1'b0, 32'hD0C20000, 4'b0100, 1'b0, 8'hC2));
        vecs.push_back(mk(4'b1001, 1'b0, 32'hD0C20000, 4'b0000, 1'b0, 8'h00));
        vecs.push_back(mk(4'b1001, 1'b0, 32'hD0C20000, 4'b1000, 1'b1, 8'hD0));
        vecs.push_back(mk(4'b0000, 1'b0, 32'hD1000000, 4'b1000, 1'b0, 8'hD1));
        vecs.push_back(mk(4'b0000, 1'b0, 32'hD1000000, 4'b0000, 1'b0, 8'h00));

        // Reset held with all requesters active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle("reset_hold", 4'b0000, 1'b0, 8'h00);
        chk("reset_starve", {31'h0, starve_err}, 32'h0);

        // First arbitration after reset uses ptr=0.
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_cycle("post_rst_idle", 4'b0000, 1'b0, 8'h00);
        @(posedge clk); #1;
        sb.push_back(8'h10);
        @(negedge clk);
        check_cycle("post_rst_grant0", 4'b0001, 1'b1, 8'h10);

        // Asynchronous reset mid-burst clears outputs without waiting for a clock.
        @(posedge clk); #1;
        sb.push_back(8'h10);
        @(negedge clk);
        check_cycle("burst_2nd", 4'b0001, 1'b1, 8'h10);
        #2;
        rst = 1'b1;
        #1;
        chk("midburst_rst_grant", {28'h0, grant}, 32'h0);
        chk("midburst_rst_push", {31'h0, push}, 32'h0);
        chk("midburst_rst_data", {24'h0, data_out}, 32'h0);
        req = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            req      = vecs[i].req;
            full     = vecs[i].full;
            req_data = vecs[i].rdata;
            if (vecs[i].exp_push) sb.push_back(vecs[i].exp_data);
            @(negedge clk);
            check_cycle($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_push, vecs[i].exp_data);
        end

        // Rotation with all four requesting: one idle cycle then four pushes per owner.
        @(posedge clk); #1;
        rst = 1'b1;
        req = 4'b1111;
        full = 1'b0;
        req_data = 32'hD3D2D1D0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            int          own;
            logic [3:0]  eg;
            own = (k / 5) % 4;
            if (k % 5 == 0) begin
                eg = 4'b0000;
            end else begin
                eg = 4'b0001 << own;
                sb.push_back(8'hD0 + 8'(own));
            end
            @(negedge clk);
            check_cycle($sformatf("rot%0d", k), eg, (k % 5 != 0), (k % 5 == 0) ? 8'h00 : 8'hD0 + 8'(own));
            @(posedge clk); #1;
        end

`ifdef FIFO_ARB_STARVE_CHK_EN
        // Owner 0 stalled by full while requester 1 waits.
        rst = 1'b1;
        req = 4'b0011;
        full = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("starve_after_1wait", {31'h0, starve_err}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("starve_after_3wait", {31'h0, starve_err}, 32'h1);
        @(posedge clk); #1;
        req = 4'b0000;
        full = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("starve_sticky", {31'h0, starve_err}, 32'h1);
`else
        @(negedge clk);
        chk("starve_off", {31'h0, starve_err}, 32'h0);
`endif

        chk("sb_drained", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters; legal range 2..16.
REQ-003 Parameter BURST, default 4, maximum pushes per grant; must be >= 1.
REQ-004 Parameter STARVE_MAX, default 32, wait-cycle limit for the starvation check.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 req  input  NREQ  per-requester push request; must be held until granted.
REQ-008 req_data  input  NREQ*WIDTH  packed request data; slice i belongs to requester i.
REQ-009 full  input  1  full flag from the downstream shift-register FIFO.
REQ-010 grant  output  NREQ  one-hot or zero; marks the current owner.
REQ-011 push  output  1  push strobe to the FIFO.
REQ-012 data_out  output  WIDTH  data to the FIFO; equals the owner's req_data slice.
REQ-013 starve_err  output  1  sticky starvation flag.

Function
REQ-014 The FSM shall have two states: IDLE (no owner) and BUSY (owner registered).
REQ-015 IDLE to BUSY: if any req bit is high, a round-robin pick starting at ptr shall register the owner.
  - Grant appears the cycle after the request is seen (1-cycle latency).
  - If no req bit is high, the FSM stays in IDLE.
REQ-016 In IDLE, grant, push and data_out shall all be 0.
REQ-017 In BUSY, grant shall be one-hot at the owner.
  - push = req[owner] & ~full.
  - data_out = req_data[owner], combinational.
REQ-018 push shall never assert while full is high.
REQ-019 Burst counter: increments on each cycle with push high; cycles stalled by full shall not count.
REQ-020 Release shall occur on the cycle where either of these holds:
  - push is high and the counter equals BURST-1; or
  - req[owner] is low (no push that cycle).
  - On release: next state IDLE, counter cleared to 0, ptr <= (owner+1) mod NREQ.
REQ-021 Simultaneous req from several requesters in IDLE: the first set bit at or after ptr, wrapping, wins.
REQ-022 Non-owner req bits shall be ignored in BUSY.
REQ-023 With all NREQ requesters continuously requesting, grants shall rotate 0,1,...,NREQ-1,0.

Reset
REQ-024 Asserting rst at any time, including mid-burst, shall immediately force:
  - state IDLE, ptr 0, counter 0, grant 0, push 0, data_out 0, starve_err 0.
REQ-025 The first arbitration after rst deasserts shall use ptr=0.

Configuration
REQ-026 Macro FIFO_ARB_STARVE_CHK_EN selects the starvation check.
  - Defined: each requester has a wait counter, incremented while req[i] & ~grant[i] and cleared when grant[i] is high.
  - Defined: starve_err sets when any counter reaches STARVE_MAX and stays set until reset.
  - Undefined: the counters are absent and starve_err is tied to 0.

Structure
REQ-027 Package fifo_arb_pkg shall hold:
  - the FSM state typedef (IDLE, BUSY);
  - a localparam function computing the ptr/owner width as $clog2(NREQ).
REQ-028 Sub-module rr_pick shall be a combinational round-robin picker.
  - Inputs: req vector and ptr.
  - Outputs: index and valid.
REQ-029 The arbiter and the downstream shift-register FIFO shall share WIDTH.

Verification
REQ-030 The bench shall cover these directed scenarios (NREQ=4, BURST=4, WIDTH=8):
  - Reset: rst=1 with req=4'b1111 -> grant=0, push=0. After rst=0: next cycle grant=4'b0001.
  - Full burst: req=4'b0001, data 0xA0..0xA3, full=0 -> 4 pushes of 0xA0..0xA3, then IDLE, ptr=1.
  - Stall: full=1 for 3 cycles after the second push -> push=0, grant held, counter stays 2; 2 more pushes once full=0.
  - Early drop: owner 2 drops req after 2 pushes -> release on the drop cycle, ptr=3; next grant goes to 3 if requesting.
  - Rotation: req=4'b1111 held -> owners in order 0,1,2,3,0, each with 4 pushes.
  - Starvation, FIFO_ARB_STARVE_CHK_EN defined, STARVE_MAX=3: owner 0 stalled by full=1 while req[1]=1 -> starve_err=1 on the 3rd wait cycle and stays 1.
